// File: rtl/voxel_gpu_pkg.sv
// Shared types and default geometry for the voxel_gpu drawing engines.
package voxel_gpu_pkg;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_WRITE,
        FILL_DONE
    } fill_state_t;

    typedef logic [15:0] rgb565_t;

    localparam int DEFAULT_STRIDE_BYTES = 1024;
    localparam int FB_WIDTH             = 320;
    localparam int FB_HEIGHT            = 240;

endpackage

// File: rtl/raster_scan_counter.sv
// Row-major raster position generator: x steps by two pixels per word and
// row_base accumulates the byte stride, so no multiplier is needed.
module raster_scan_counter #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int STRIDE_BYTES = 1024,
    localparam int XW          = $clog2(WIDTH + 1),
    localparam int YW          = $clog2(HEIGHT + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          init,
    input  logic          advance,
    input  logic [31:0]   base,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [31:0]   row_base,
    output logic          last
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 2);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [31:0]   STRIDE = 32'(STRIDE_BYTES);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   row_base_q, row_base_d;

    // Advancing past the final word holds the position; the owner stops there.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        if (init) begin
            x_d        = '0;
            y_d        = '0;
            row_base_d = base;
        end else if (advance) begin
            if (x_q < X_LAST) begin
                x_d = x_q + XW'(2);
            end else if (y_q < Y_LAST) begin
                x_d        = '0;
                y_d        = y_q + YW'(1);
                row_base_d = row_base_q + STRIDE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign row_base = row_base_q;
    assign last     = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/framebuffer_fill.sv
// Solid-colour pixel buffer fill: writes {color,color} to every word of the
// buffer over an Avalon-MM master, then pulses done for one cycle.
module framebuffer_fill
    import voxel_gpu_pkg::*;
#(
    parameter int WIDTH        = FB_WIDTH,
    parameter int HEIGHT       = FB_HEIGHT,
    parameter int STRIDE_BYTES = DEFAULT_STRIDE_BYTES,
    parameter int PIXEL_BYTES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic [31:0] m1_address,
    output logic [31:0] m1_writedata,
    output logic        m1_write,
    input  logic        m1_waitrequest
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);

    if (PIXEL_BYTES != 2) begin : g_bad_pixel_bytes
        $error("framebuffer_fill: PIXEL_BYTES must be 2");
    end
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("framebuffer_fill: WIDTH must be even and at least 2");
    end
    if (HEIGHT < 1) begin : g_bad_height
        $error("framebuffer_fill: HEIGHT must be at least 1");
    end

    fill_state_t   state_q, state_d;
    rgb565_t       color_q, color_d;

    logic          scan_init;
    logic          scan_advance;
    logic          scan_last;
    logic [XW-1:0] scan_x;
    logic [YW-1:0] unused_scan_y;
    logic [31:0]   scan_row_base;

    assign scan_init    = (state_q == FILL_IDLE) && start;
    assign scan_advance = (state_q == FILL_WRITE) && !m1_waitrequest;

    raster_scan_counter #(
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .STRIDE_BYTES (STRIDE_BYTES)
    ) u_scan (
        .clock    (clock),
        .reset    (reset),
        .init     (scan_init),
        .advance  (scan_advance),
        .base     (base_addr),
        .x        (scan_x),
        .y        (unused_scan_y),
        .row_base (scan_row_base),
        .last     (scan_last)
    );

    // Start is only honoured in IDLE, so requests during a fill are dropped.
    always_comb begin
        state_d = state_q;
        color_d = color_q;
        case (state_q)
            FILL_IDLE: begin
                if (start) begin
                    state_d = FILL_WRITE;
                    color_d = color;
                end
            end
            FILL_WRITE: begin
                if (!m1_waitrequest && scan_last) begin
                    state_d = FILL_DONE;
                end
            end
            FILL_DONE: state_d = FILL_IDLE;
            default:   state_d = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL_IDLE;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
        end
    end

    assign busy         = (state_q != FILL_IDLE);
    assign done         = (state_q == FILL_DONE);
    assign m1_write     = (state_q == FILL_WRITE);
    assign m1_address   = scan_row_base + (32'(scan_x) << 1);
    assign m1_writedata = {color_q, color_q};

endmodule

// File: tb/tb_framebuffer_fill.sv
// Self-checking bench: a small 4x2 fill instance for directed cases and a
// default-geometry instance for the full 320x240 run.
module tb_framebuffer_fill;

    localparam int STRIDE = 1024;

    logic        clock;
    logic        reset0, start0, wait0;
    logic [31:0] base0;
    logic [15:0] color0;
    logic        busy0, done0, write0;
    logic [31:0] addr0, data0;
    logic        reset1, start1, wait1;
    logic [31:0] base1;
    logic [15:0] color1;
    logic        busy1, done1, write1;
    logic [31:0] addr1, data1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Abstract model state per instance: phase 0 idle, 1 writing, 2 done.
    int          ph[2]            = '{0, 0};
    int          idx[2]           = '{0, 0};
    logic [31:0] mbase[2];
    logic [15:0] mcol[2];
    int          dn_cnt[2]        = '{0, 0};
    int          obs_acc[2]       = '{0, 0};
    logic [31:0] obs_last[2];
    int          last_done_cyc[2] = '{-1, -1};
    int          hold_cnt         = 0;
    logic [31:0] log0[$];
    int          log_cyc0[$];
    int          gaps0[$];

    framebuffer_fill #(
        .WIDTH(4), .HEIGHT(2), .STRIDE_BYTES(STRIDE), .PIXEL_BYTES(2)
    ) dut_small (
        .clock(clock), .reset(reset0), .start(start0), .base_addr(base0),
        .color(color0), .busy(busy0), .done(done0), .m1_address(addr0),
        .m1_writedata(data0), .m1_write(write0), .m1_waitrequest(wait0)
    );

    framebuffer_fill dut_big (
        .clock(clock), .reset(reset1), .start(start1), .base_addr(base1),
        .color(color1), .busy(busy1), .done(done1), .m1_address(addr1),
        .m1_writedata(data1), .m1_write(write1), .m1_waitrequest(wait1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int geom_w(input int d);
        return (d == 0) ? 4 : 320;
    endfunction

    function automatic int geom_h(input int d);
        return (d == 0) ? 2 : 240;
    endfunction

    // Word k of a fill sits at row k/(W/2), byte column 4*(k%(W/2)).
    function automatic logic [31:0] model_addr(input int d, input int k);
        int wpr;
        wpr = geom_w(d) / 2;
        return mbase[d] + 32'((k / wpr) * STRIDE) + 32'((k % wpr) * 4);
    endfunction

    // Compare one instance against the model, then step the model using the
    // inputs that the coming rising edge will sample.
    task automatic checkPort(input int d, input logic rst, input logic st, input logic wt,
                             input logic [31:0] ba, input logic [15:0] col,
                             input logic wr, input logic bsy, input logic dn,
                             input logic [31:0] ad, input logic [31:0] dt);
        checkOutput($sformatf("write%0d", d), 32'(wr), 32'(ph[d] == 1));
        checkOutput($sformatf("busy%0d", d), 32'(bsy), 32'(ph[d] != 0));
        checkOutput($sformatf("done%0d", d), 32'(dn), 32'(ph[d] == 2));
        if (ph[d] == 1) begin
            checkOutput($sformatf("addr%0d", d), ad, model_addr(d, idx[d]));
            checkOutput($sformatf("data%0d", d), dt, {mcol[d], mcol[d]});
        end
        if (dn === 1'b1) begin
            dn_cnt[d]++;
            last_done_cyc[d] = cyc;
        end
        if (wr === 1'b1 && !wt && !rst) begin
            obs_acc[d]++;
            obs_last[d] = ad;
            if (d == 0) begin
                log0.push_back(ad);
                log_cyc0.push_back(cyc);
            end
        end
        if (d == 0 && wr === 1'b1 && ad === 32'h0800_0004) hold_cnt++;
        if (rst) begin
            ph[d] = 0;
        end else begin
            case (ph[d])
                0: if (st) begin
                    ph[d]    = 1;
                    idx[d]   = 0;
                    mbase[d] = ba;
                    mcol[d]  = col;
                    if (d == 0 && last_done_cyc[0] >= 0) gaps0.push_back(cyc + 1 - last_done_cyc[0]);
                end
                1: if (!wt) begin
                    idx[d]++;
                    if (idx[d] == geom_w(d) * geom_h(d) / 2) ph[d] = 2;
                end
                default: ph[d] = 0;
            endcase
        end
    endtask

    // Single compare process for both instances, on the falling edge.
    always @(negedge clock) begin
        cyc++;
        checkPort(0, reset0, start0, wait0, base0, color0, write0, busy0, done0, addr0, data0);
        checkPort(1, reset1, start1, wait1, base1, color1, write1, busy1, done1, addr1, data1);
    end

    task automatic applyStimulus(input int d, input logic st, input logic [31:0] ba,
                                 input logic [15:0] col, input logic wt);
        if (d == 0) begin
            start0 = st; base0 = ba; color0 = col; wait0 = wt;
        end else begin
            start1 = st; base1 = ba; color1 = col; wait1 = wt;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic waitIdle(input int d, input int budget);
        int n;
        n = 0;
        while (((d == 0) ? busy0 : busy1) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput($sformatf("wait_idle%0d", d), 32'(n >= budget), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_t1[4];
        int n0, d0, h0, g0, n;
        exp_t1[0] = 32'h0800_0000;
        exp_t1[1] = 32'h0800_0004;
        exp_t1[2] = 32'h0800_0400;
        exp_t1[3] = 32'h0800_0404;

        reset0 = 1'b1; start0 = 1'b0; wait0 = 1'b0; base0 = '0; color0 = '0;
        reset1 = 1'b1; start1 = 1'b0; wait1 = 1'b0; base1 = '0; color1 = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_addr0", addr0, 32'd0);
        checkOutput("reset_data0", data0, 32'd0);
        checkOutput("reset_write0", 32'(write0), 32'd0);
        checkOutput("reset_addr1", addr1, 32'd0);
        checkOutput("reset_data1", data1, 32'd0);
        reset0 = 1'b0;
        reset1 = 1'b0;
        applyStimulus(0, 1'b0, 32'd0, 16'd0, 1'b0);

        // Back-to-back fill with no stalls.
        n0 = log0.size(); d0 = dn_cnt[0];
        applyStimulus(0, 1'b1, 32'h0800_0000, 16'hF800, 1'b0);
        start0 = 1'b0;
        waitIdle(0, 50);
        checkOutput("t1_count", 32'(log0.size() - n0), 32'd4);
        if (log0.size() - n0 == 4) begin
            for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_addr%0d", i), log0[n0 + i], exp_t1[i]);
            checkOutput("t1_consecutive", 32'(log_cyc0[n0 + 3] - log_cyc0[n0]), 32'd3);
            checkOutput("t1_done_lag", 32'(last_done_cyc[0] - log_cyc0[n0 + 3]), 32'd1);
        end
        checkOutput("t1_done_count", 32'(dn_cnt[0] - d0), 32'd1);

        // Second word stalled for three cycles.
        n0 = log0.size(); h0 = hold_cnt;
        applyStimulus(0, 1'b1, 32'h0800_0000, 16'hF800, 1'b0);
        applyStimulus(0, 1'b0, 32'h0800_0000, 16'hF800, 1'b0);
        repeat (3) applyStimulus(0, 1'b0, 32'h0800_0000, 16'hF800, 1'b1);
        applyStimulus(0, 1'b0, 32'h0800_0000, 16'hF800, 1'b0);
        waitIdle(0, 50);
        checkOutput("t2_hold_cycles", 32'(hold_cnt - h0), 32'd4);
        checkOutput("t2_count", 32'(log0.size() - n0), 32'd4);
        if (log0.size() - n0 == 4)
            for (int i = 0; i < 4; i++) checkOutput($sformatf("t2_addr%0d", i), log0[n0 + i], exp_t1[i]);

        // Start during WRITE with a different base must be ignored.
        n0 = log0.size(); d0 = dn_cnt[0];
        applyStimulus(0, 1'b1, 32'h0800_0000, 16'hF800, 1'b0);
        applyStimulus(0, 1'b1, 32'h0900_0000, 16'h07E0, 1'b0);
        start0 = 1'b0;
        waitIdle(0, 50);
        checkOutput("t3_count", 32'(log0.size() - n0), 32'd4);
        for (int i = n0; i < log0.size(); i++) checkOutput("t3_region", 32'(log0[i][31:16]), 32'h0800);
        checkOutput("t3_done_count", 32'(dn_cnt[0] - d0), 32'd1);

        // Reset after the second accepted word, with the bus stalled.
        d0 = dn_cnt[0];
        applyStimulus(0, 1'b1, 32'h0800_0000, 16'hF800, 1'b0);
        applyStimulus(0, 1'b0, 32'h0800_0000, 16'hF800, 1'b0);
        applyStimulus(0, 1'b0, 32'h0800_0000, 16'hF800, 1'b0);
        reset0 = 1'b1;
        applyStimulus(0, 1'b0, 32'h0800_0000, 16'hF800, 1'b1);
        checkOutput("t4_write", 32'(write0), 32'd0);
        checkOutput("t4_busy", 32'(busy0), 32'd0);
        checkOutput("t4_addr", addr0, 32'd0);
        reset0 = 1'b0;
        repeat (2) applyStimulus(0, 1'b0, 32'h0800_0000, 16'hF800, 1'b0);
        checkOutput("t4_no_done", 32'(dn_cnt[0] - d0), 32'd0);
        n0 = log0.size();
        applyStimulus(0, 1'b1, 32'h0800_0000, 16'h1234, 1'b0);
        start0 = 1'b0;
        waitIdle(0, 50);
        checkOutput("t4_refill_count", 32'(log0.size() - n0), 32'd4);
        if (log0.size() > n0) checkOutput("t4_refill_first", log0[n0], 32'h0800_0000);

        // Full default-geometry fill under random stalls.
        n0 = obs_acc[1]; d0 = dn_cnt[1];
        applyStimulus(1, 1'b1, 32'h0800_0000, 16'h0000, 1'b0);
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 70000) begin
            wait1 = ($urandom_range(0, 7) == 0);
            @(posedge clock);
            #1;
            n++;
        end
        wait1 = 1'b0;
        checkOutput("t5_timeout", 32'(n >= 70000), 32'd0);
        checkOutput("t5_count", 32'(obs_acc[1] - n0), 32'd38400);
        // Row 239 starts at 239*1024 = 0x3BC00; word x=318 adds 2*318 = 0x27C.
        checkOutput("t5_last_addr", obs_last[1], 32'h0803_BE7C);
        checkOutput("t5_done_count", 32'(dn_cnt[1] - d0), 32'd1);

        // Start held high: fills repeat with a two-cycle done-to-write gap.
        d0 = dn_cnt[0]; g0 = gaps0.size();
        repeat (21) applyStimulus(0, 1'b1, 32'h0800_0000, 16'h001F, 1'b0);
        start0 = 1'b0;
        waitIdle(0, 50);
        checkOutput("t6_done_count", 32'(dn_cnt[0] - d0), 32'd4);
        checkOutput("t6_gap_count", 32'(gaps0.size() - g0), 32'd4);
        for (int i = g0 + 1; i < gaps0.size(); i++) checkOutput("t6_gap", 32'(gaps0[i]), 32'd2);

        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
